// File: rtl/wb_sram_arbiter.sv
// rtl/wb_sram_arbiter.sv - round-robin Wishbone arbiter sharing one SRAM slave between masters
// Optional stalled-beat timeout with ABORT state: define WB_ARB_TIMEOUT_EN.
module wb_sram_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*8-1:0]          m_dat_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_rty_o,
    output logic [NUM_MASTERS-1:0]            m_stall_o,
    output logic [7:0]                        m_dat_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [7:0]                        s_dat_o,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_rty_i,
    input  logic                              s_stall_i,
    input  logic [7:0]                        s_dat_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

    state_t                 state, state_n;
    logic [NUM_MASTERS-1:0] grant, grant_n;
    logic [IW-1:0]          gidx, gidx_n;
    logic [IW-1:0]          rr_ptr, rr_n;
    logic [IW-1:0]          pick_idx;
    logic [IW-1:0]          gidx_inc;
    logic                   found;
    logic                   timeout_hit;

    // Scan cyc requests starting at rr_ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        int j;
        found    = 1'b0;
        pick_idx = '0;
        j        = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            if (!found && m_cyc_i[j]) begin
                found    = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    assign gidx_inc = (int'(gidx) == NUM_MASTERS - 1) ? '0 : gidx + IW'(1);

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       stalled;

    // The beat that would make the count reach the limit is the one flagged.
    assign stalled     = (state == BUSY) && s_stb_o && !s_ack_i;
    assign timeout_hit = stalled && (to_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          to_cnt <= 8'd0;
        else if (state != BUSY || s_ack_i)    to_cnt <= 8'd0;
        else if (stalled)                     to_cnt <= to_cnt + 8'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            grant  <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            gidx   <= gidx_n;
            rr_ptr <= rr_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        gidx_n  = gidx;
        rr_n    = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    grant_n = NUM_MASTERS'(1) << pick_idx;
                    gidx_n  = pick_idx;
                end
            end
            BUSY: begin
                if (!m_cyc_i[gidx]) begin
                    state_n = IDLE;
                    grant_n = '0;
                    rr_n    = gidx_inc;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_n = ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (!m_cyc_i[gidx]) begin
                    state_n = IDLE;
                    grant_n = '0;
                    rr_n    = gidx_inc;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // Only the granted master is connected; everyone else is held stalled.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = 8'd0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_rty_o   = '0;
        m_stall_o = '1;
        if (state == BUSY) begin
            s_cyc_o         = m_cyc_i[gidx];
            s_stb_o         = m_stb_i[gidx];
            s_we_o          = m_we_i[gidx];
            s_adr_o         = m_adr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o         = m_dat_i[int'(gidx)*8 +: 8];
            m_ack_o[gidx]   = s_ack_i;
            m_err_o[gidx]   = s_err_i | timeout_hit;
            m_rty_o[gidx]   = s_rty_i;
            m_stall_o[gidx] = s_stall_i;
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// tb/tb_wb_sram_arbiter.sv - directed self-checking bench for wb_sram_arbiter with a registered-ack SRAM model
module tb_wb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] m_cyc, m_stb, m_we;
    logic [3:0] m_adr;
    logic [15:0] m_dat;
    logic [1:0] m_ack, m_err, m_rty, m_stall;
    logic [7:0] m_rdat;
    logic       s_cyc, s_stb, s_we;
    logic [1:0] s_adr;
    logic [7:0] s_wdat;
    logic       s_ack;
    logic [7:0] s_rdat;
    logic [1:0] grant;
    logic       busy;
    logic       stuck_ack = 1'b0;
    logic [7:0] mem [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_sram_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(2), .TIMEOUT_CYCLES(15)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty), .m_stall_o(m_stall), .m_dat_o(m_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_ack_i(s_ack), .s_err_i(1'b0), .s_rty_i(1'b0), .s_stall_i(1'b0), .s_dat_i(s_rdat),
        .grant_o(grant), .busy_o(busy)
    );

    // Registered-ack SRAM slave: every accepted stb cycle is acked on the next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack  <= 1'b0;
            s_rdat <= 8'd0;
        end else begin
            s_ack <= s_cyc & s_stb & !stuck_ack;
            if (s_cyc && s_stb && s_we)  mem[s_adr] <= s_wdat;
            if (s_cyc && s_stb && !s_we) s_rdat <= mem[s_adr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00; m_adr = 4'd0; m_dat = 16'd0;
        stuck_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00; m_adr = 4'd0; m_dat = 16'd0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin failures++; $display("FAIL reset_slave got=%b%b exp=00", s_cyc, s_stb); end
        checks++; if (m_stall !== 2'b11) begin failures++; $display("FAIL reset_stall got=%b exp=11", m_stall); end
        checks++; if (m_ack !== 2'b00 || m_err !== 2'b00 || m_rty !== 2'b00) begin failures++; $display("FAIL reset_resp got=%b%b%b exp=000000", m_ack, m_err, m_rty); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        apply_reset();
        step(); m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_adr[1:0] = 2'd1; m_dat[7:0] = 8'hA5;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL single_c0_grant got=%b exp=00", grant); end
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_c1_grant got=%b exp=01", grant); end
        checks++; if ({s_cyc, s_stb, s_we, s_adr, s_wdat} !== {3'b111, 2'd1, 8'hA5}) begin failures++; $display("FAIL single_c1_slave got=%b%b%b %h %h exp=111 1 a5", s_cyc, s_stb, s_we, s_adr, s_wdat); end
        checks++; if (m_stall !== 2'b10) begin failures++; $display("FAIL single_c1_stall got=%b exp=10", m_stall); end
        step(); m_we = 2'b00;
        @(negedge clk);
        checks++; if (m_ack !== 2'b01) begin failures++; $display("FAIL single_wr_ack got=%b exp=01", m_ack); end
        step(); m_stb = 2'b00;
        @(negedge clk);
        checks++; if (m_ack !== 2'b01) begin failures++; $display("FAIL single_rd_ack got=%b exp=01", m_ack); end
        checks++; if (m_rdat !== 8'hA5) begin failures++; $display("FAIL single_rd_data got=%h exp=a5", m_rdat); end
        step(); m_cyc = 2'b00;
        @(negedge clk);
        checks++; if (m_ack !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL single_tail got=ack%b busy%b exp=ack00 busy1", m_ack, busy); end
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL single_release got=%b busy%b exp=00 busy0", grant, busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [6];
        logic [1:0] drv_c [6];
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        drv_c = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            step(); m_cyc = drv_c[c];
            @(negedge clk);
            checks++; if (grant !== exp_g[c]) begin failures++; $display("FAIL rr_cycle%0d got=%b exp=%b", c, grant, exp_g[c]); end
        end
        step(); step();
    endtask

    task automatic test_burst();
        int acks;
        logic [7:0] exp_d;
        apply_reset();
        acks = 0;
        step(); m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_adr[3:2] = 2'd0; m_dat[15:8] = 8'h11;
        step(); m_cyc = 2'b11;
        @(negedge clk);
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL burst_grant got=%b exp=10", grant); end
        for (int b = 1; b <= 4; b++) begin
            step();
            if (b < 4) begin m_adr[3:2] = 2'(b); m_dat[15:8] = 8'(8'h11 * (b + 1)); end
            else m_stb = 2'b00;
            @(negedge clk);
            if (m_ack === 2'b10 && grant === 2'b10) acks++;
            checks++; if (m_ack !== 2'b10 || grant !== 2'b10) begin failures++; $display("FAIL burst_beat%0d got=ack%b grant%b exp=ack10 grant10", b, m_ack, grant); end
        end
        checks++; if (acks !== 4) begin failures++; $display("FAIL burst_ack_count got=%0d exp=4", acks); end
        step(); m_cyc = 2'b01;
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL burst_gap got=%b exp=00", grant); end
        step(); m_stb = 2'b01; m_we = 2'b00; m_adr[1:0] = 2'd0;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL burst_m0_grant got=%b exp=01", grant); end
        for (int b = 0; b < 4; b++) begin
            step();
            if (b < 3) m_adr[1:0] = 2'(b + 1);
            else m_stb = 2'b00;
            exp_d = 8'(8'h11 * (b + 1));
            @(negedge clk);
            checks++; if (m_ack !== 2'b01 || m_rdat !== exp_d) begin failures++; $display("FAIL burst_read%0d got=ack%b data%h exp=ack01 data%h", b, m_ack, m_rdat, exp_d); end
        end
        step(); m_cyc = 2'b00;
        step(); step();
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(); m_cyc = 2'b01;
        step(); m_cyc = 2'b10;
        step();
        step(); m_stb = 2'b10; m_we = 2'b00; m_adr[3:2] = 2'd2;
        @(negedge clk);
        checks++; if (grant !== 2'b10 || s_cyc !== 1'b1) begin failures++; $display("FAIL arst_pre got=grant%b cyc%b exp=grant10 cyc1", grant, s_cyc); end
        step();
        @(negedge clk);
        checks++; if (m_ack !== 2'b10) begin failures++; $display("FAIL arst_pre_ack got=%b exp=10", m_ack); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (s_cyc !== 1'b0 || grant !== 2'b00 || m_ack !== 2'b00) begin failures++; $display("FAIL arst_immediate got=cyc%b grant%b ack%b exp=cyc0 grant00 ack00", s_cyc, grant, m_ack); end
        m_cyc = 2'b11; m_stb = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL arst_rr_ptr got=%b exp=01", grant); end
        step(); m_cyc = 2'b00;
        step(); step();
    endtask

    task automatic test_drop_with_ack();
        apply_reset();
        step(); m_cyc = 2'b11; m_stb = 2'b01; m_we = 2'b01; m_adr[1:0] = 2'd2; m_dat[7:0] = 8'h5A;
        step();
        step(); m_cyc = 2'b10; m_stb = 2'b00;
        @(negedge clk);
        checks++; if (m_ack !== 2'b01) begin failures++; $display("FAIL drop_ack got=%b exp=01", m_ack); end
        step();
        @(negedge clk);
        checks++; if (m_ack !== 2'b00 || grant !== 2'b00) begin failures++; $display("FAIL drop_idle got=ack%b grant%b exp=ack00 grant00", m_ack, grant); end
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b10 || m_ack !== 2'b00) begin failures++; $display("FAIL drop_next_grant got=grant%b ack%b exp=grant10 ack00", grant, m_ack); end
        step(); m_cyc = 2'b00;
        step(); step();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int err_cycles;
        apply_reset();
        stuck_ack = 1'b1;
        err_cycles = 0;
        step(); m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; m_adr[1:0] = 2'd3;
        for (int c = 1; c <= 14; c++) begin
            step();
            @(negedge clk);
            if (m_err !== 2'b00) err_cycles++;
        end
        checks++; if (err_cycles !== 0) begin failures++; $display("FAIL to_early_err got=%0d exp=0", err_cycles); end
        step();
        @(negedge clk);
        checks++; if (m_err !== 2'b01 || s_cyc !== 1'b1) begin failures++; $display("FAIL to_err_pulse got=err%b cyc%b exp=err01 cyc1", m_err, s_cyc); end
        step();
        @(negedge clk);
        checks++; if (m_err !== 2'b00 || s_cyc !== 1'b0 || busy !== 1'b1 || m_stall !== 2'b11) begin failures++; $display("FAIL to_abort got=err%b cyc%b busy%b stall%b exp=err00 cyc0 busy1 stall11", m_err, s_cyc, busy, m_stall); end
        step();
        @(negedge clk);
        checks++; if (s_cyc !== 1'b0 || grant !== 2'b01) begin failures++; $display("FAIL to_hold got=cyc%b grant%b exp=cyc0 grant01", s_cyc, grant); end
        step(); m_cyc = 2'b00; m_stb = 2'b00; stuck_ack = 1'b0;
        step(); m_cyc = 2'b01;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL to_release got=grant%b busy%b exp=grant00 busy0", grant, busy); end
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || s_cyc !== 1'b1) begin failures++; $display("FAIL to_regrant got=grant%b cyc%b exp=grant01 cyc1", grant, s_cyc); end
        step(); m_cyc = 2'b00;
        step(); step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_async_reset();
        test_drop_with_ack();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
